qdiv_seq: RTL and testbench
===========================

QDIV_SEQ -- requirements
Module: qdiv_seq

Interface
REQ-001 The module SHALL have parameter Q, default 15: number of fractional bits.
REQ-002 The module SHALL have parameter N, default 32: total word width; bit N-1 is sign, bits N-2:0 are magnitude (sign-magnitude).
REQ-003 The module SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-005 The module SHALL have port start, input, 1 bit: request a division; sampled only in IDLE.
REQ-006 The module SHALL have port dividend, input, N bits: sign-magnitude Q-format numerator, captured when start is accepted.
REQ-007 The module SHALL have port divisor, input, N bits: sign-magnitude Q-format denominator, captured when start is accepted.
REQ-008 The module SHALL have port quotient, output, N bits: sign-magnitude Q-format result, held from done until the next accepted start.
REQ-009 The module SHALL have port busy, output, 1 bit: high in CALC and DONE.
REQ-010 The module SHALL have port done, output, 1 bit: one-cycle pulse marking quotient valid.
REQ-011 The module SHALL have port overflow, output, 1 bit: result magnitude saturated; valid with done, held with quotient.
REQ-012 The module SHALL have port div_by_zero, output, 1 bit: divisor magnitude was zero; valid with done, held with quotient.

Function
REQ-013 The FSM SHALL have three states: IDLE, CALC and DONE.
REQ-014 In IDLE with start=1, the module SHALL capture the operands, clear the overflow and div_by_zero flags, and go to CALC; if the divisor magnitude is 0 it SHALL go straight to DONE instead.
REQ-015 CALC SHALL run restoring division on magnitudes, one quotient bit per cycle, for exactly N-1+Q cycles (46 at defaults); the numerator is |dividend| shifted left by Q, a width of N-1+Q bits.
REQ-016 CALC SHALL then go to DONE; DONE SHALL last one cycle with done=1 and then return to IDLE.
REQ-017 Latency: if start is accepted at edge T, done SHALL be high in the cycle after edge T+N+Q (T+47 at defaults), or after edge T+1 on divide-by-zero.
REQ-018 The magnitude SHALL be floor(|a|*2^Q / |b|), i.e. truncated toward zero.
REQ-019 If any raw quotient bit at position N-1 or above is set, the magnitude SHALL saturate to all ones (2^(N-1)-1) and overflow SHALL be 1.
REQ-020 The sign SHALL be dividend[N-1] XOR divisor[N-1]; it SHALL be forced to 0 when the magnitude is 0, so there is no negative zero.
REQ-021 On divide-by-zero, the magnitude SHALL be all ones, the sign SHALL be dividend[N-1], and div_by_zero SHALL be 1.
REQ-022 A start asserted while busy=1 SHALL be ignored and SHALL not be queued; operand changes during CALC SHALL not affect the result.
REQ-023 A start asserted in the DONE cycle SHALL be ignored; start is accepted again from the following IDLE cycle.
REQ-024 quotient, overflow and div_by_zero SHALL update only on the transition into DONE.

Reset
REQ-025 While rst_n=0 at a rising edge, the state SHALL become IDLE and quotient, busy, done, overflow, div_by_zero and the internal counter and remainder SHALL be 0.
REQ-026 A reset during CALC or DONE SHALL abort the operation; no done pulse SHALL follow for that operation.
REQ-027 start SHALL be ignored in any cycle where rst_n=0.

Verification
REQ-028 The bench SHALL cover basic division: dividend=0x00008000 (1.0), divisor=0x00004000 (0.5) -> quotient=0x00010000, overflow=0, done exactly 47 cycles after acceptance.
REQ-029 The bench SHALL cover signed truncation: dividend=0x80018000 (-3.0), divisor=0x0000C000 (1.5) -> 0x80010000; and dividend=0x00008000, divisor=0x00018000 -> 0x00002AAA.
REQ-030 The bench SHALL cover overflow: dividend=0x7FFFFFFF, divisor=0x00000001 -> quotient=0x7FFFFFFF, overflow=1.
REQ-031 The bench SHALL cover divide-by-zero: dividend=0x00008000, divisor=0x80000000 -> quotient=0x7FFFFFFF, div_by_zero=1, done one cycle after acceptance.
REQ-032 The bench SHALL cover negative zero: dividend=0x80000000, divisor=0x00008000 -> quotient=0x00000000.
REQ-033 The bench SHALL cover start while busy and reset mid-operation: a second start 10 cycles after acceptance -> ignored, with a single done; rst_n=0 for one cycle 20 cycles after acceptance -> all outputs 0 and no done pulse, then a new start completes normally.

Source files
------------

// File: rtl/qdiv_seq.sv
// qdiv_seq: sequential sign-magnitude Q-format divider.
// The magnitude is found by restoring division, one quotient bit per cycle.
//
// Ports
//   clk          in   rising-edge clock
//   rst_n        in   synchronous active-low reset
//   start        in   request a division; honoured only when idle and not busy
//   dividend     in   N-bit sign-magnitude numerator, captured on accepted start
//   divisor      in   N-bit sign-magnitude denominator, captured on accepted start
//   quotient     out  N-bit sign-magnitude result, held until the next result
//   busy         out  operation in flight, including the done cycle
//   done         out  one-cycle pulse: quotient and flags are valid
//   overflow     out  result magnitude saturated
//   div_by_zero  out  divisor magnitude was zero
//
// The FSM outputs busy and done are registered from the state. They therefore lag it
// by one cycle. done rises the cycle after the state leaves DONE. Because of that lag,
// a start is accepted only when the state is IDLE and busy is low. This also rejects a
// start in the done cycle.
module qdiv_seq #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] quotient,
  output logic         busy,
  output logic         done,
  output logic         overflow,
  output logic         div_by_zero
);

  localparam int unsigned MagW = N - 1;
  localparam int unsigned NumW = MagW + Q;
  localparam int unsigned CntW = $clog2(NumW);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [MagW-1:0]   rem_q, rem_d;
  // The numerator shifts out at the top as quotient bits shift in at the bottom.
  logic [NumW-1:0]   num_q, num_d;
  logic [MagW-1:0]   den_q, den_d;
  logic              sgn_q, sgn_d;
  logic [N-1:0]      quotient_q, quotient_d;
  logic              ovf_q, ovf_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [MagW:0]     rem_shift;
  logic [MagW:0]     diff;
  logic              qbit;
  logic              sat;
  logic [MagW-1:0]   mag;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    num_d      = num_q;
    den_d      = den_q;
    sgn_d      = sgn_q;
    quotient_d = quotient_q;
    ovf_d      = ovf_q;
    dbz_d      = dbz_q;
    busy_d     = (state_q != StIdle);
    done_d     = (state_q == StDone);
    rem_shift  = '0;
    diff       = '0;
    qbit       = 1'b0;
    sat        = 1'b0;
    mag        = '0;

    unique case (state_q)
      StIdle: begin
        if (start && !busy_q) begin
          num_d = {dividend[MagW-1:0], {Q{1'b0}}};
          den_d = divisor[MagW-1:0];
          sgn_d = dividend[N-1] ^ divisor[N-1];
          rem_d = '0;
          cnt_d = '0;
          ovf_d = 1'b0;
          dbz_d = 1'b0;
          if (divisor[MagW-1:0] == '0) begin
            dbz_d      = 1'b1;
            quotient_d = {dividend[N-1], {MagW{1'b1}}};
            state_d    = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        rem_shift = {rem_q, num_q[NumW-1]};
        if (rem_shift >= {1'b0, den_q}) begin
          diff  = rem_shift - {1'b0, den_q};
          rem_d = diff[MagW-1:0];
          qbit  = 1'b1;
        end else begin
          rem_d = rem_shift[MagW-1:0];
        end
        num_d = {num_q[NumW-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntW'(NumW - 1)) begin
          // Any raw quotient bit at or above the sign position means saturation.
          sat        = |num_d[NumW-1:MagW];
          mag        = sat ? {MagW{1'b1}} : num_d[MagW-1:0];
          quotient_d = {sgn_q & (mag != '0), mag};
          ovf_d      = sat;
          state_d    = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      rem_q      <= '0;
      num_q      <= '0;
      den_q      <= '0;
      sgn_q      <= 1'b0;
      quotient_q <= '0;
      ovf_q      <= 1'b0;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rem_q      <= rem_d;
      num_q      <= num_d;
      den_q      <= den_d;
      sgn_q      <= sgn_d;
      quotient_q <= quotient_d;
      ovf_q      <= ovf_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign quotient    = quotient_q;
  assign overflow    = ovf_q;
  assign div_by_zero = dbz_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_qdiv_seq.sv
// tb_qdiv_seq: directed self-checking bench for qdiv_seq at default parameters.
module tb_qdiv_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [31:0] quotient;
  logic        busy;
  logic        done;
  logic        overflow;
  logic        div_by_zero;

  int n_tests = 0;
  int n_fail  = 0;

  qdiv_seq #(.Q(15), .N(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .quotient   (quotient),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One division. Operands are scrambled right after acceptance, so the result must
  // come from the captured copies. lat counts edges from acceptance to the first
  // sample with done high.
  task automatic run_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic exp_ovf,
                         input logic exp_dbz, input int exp_lat);
    int lat;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    lat = 0;
    while (done !== 1'b1 && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, " quotient"}, quotient, exp_q);
    chk({tag, " overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    chk({tag, " div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    chk({tag, " busy in done cycle"}, {31'd0, busy}, 32'd1);
    @(posedge clk);
    #1;
    chk({tag, " done pulse width"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    int n_done;
    int first;

    // Reset.
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset quotient", quotient, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset overflow", {31'd0, overflow}, 32'd0);
    chk("reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed divisions.
    run_div("basic 1.0/0.5", 32'h0000_8000, 32'h0000_4000, 32'h0001_0000, 1'b0, 1'b0, 47);
    run_div("neg -3.0/1.5", 32'h8001_8000, 32'h0000_C000, 32'h8001_0000, 1'b0, 1'b0, 47);
    run_div("trunc 1/3", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 47);
    run_div("overflow", 32'h7FFF_FFFF, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 47);
    run_div("neg overflow", 32'h8001_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0, 47);
    run_div("max no ovf", 32'h7FFF_FFFF, 32'h0000_8000, 32'h7FFF_FFFF, 1'b0, 1'b0, 47);
    run_div("div by zero", 32'h0000_8000, 32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 1'b1, 1);
    run_div("neg div by zero", 32'h8000_8000, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b1, 1);
    run_div("neg zero", 32'h8000_0000, 32'h0000_8000, 32'h0000_0000, 1'b0, 1'b0, 47);

    // Start while busy: a second request 10 cycles in must be dropped.
    @(negedge clk);
    dividend = 32'h0000_8000;
    divisor  = 32'h0000_4000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    n_done = 0;
    first  = 0;
    for (int i = 1; i <= 120; i++) begin
      if (i == 10) begin
        start    = 1'b1;
        dividend = 32'h7FFF_FFFF;
        divisor  = 32'h0000_0001;
      end
      if (i == 11) start = 1'b0;
      @(posedge clk);
      #1;
      if (done === 1'b1) begin
        n_done++;
        if (first == 0) first = i;
      end
    end
    chk("busy start done count", 32'(n_done), 32'd1);
    chk("busy start latency", 32'(first), 32'd47);
    chk("busy start quotient", quotient, 32'h0001_0000);
    chk("busy start overflow", {31'd0, overflow}, 32'd0);

    // Start raised in the done cycle must be ignored.
    @(negedge clk);
    dividend = 32'h0000_8000;
    divisor  = 32'h0000_0000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    chk("done-cycle setup done", {31'd0, done}, 32'd1);
    start    = 1'b1;
    dividend = 32'h0000_8000;
    divisor  = 32'h0000_4000;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("done-cycle start busy", {31'd0, busy}, 32'd0);
    chk("done-cycle start quotient", quotient, 32'h7FFF_FFFF);

    // Reset 20 cycles into an operation, with start held during the reset cycle.
    @(negedge clk);
    dividend = 32'h0000_8000;
    divisor  = 32'h0001_8000;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    rst_n = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    chk("mid reset quotient", quotient, 32'h0);
    chk("mid reset busy", {31'd0, busy}, 32'd0);
    chk("mid reset done", {31'd0, done}, 32'd0);
    chk("mid reset overflow", {31'd0, overflow}, 32'd0);
    chk("mid reset div_by_zero", {31'd0, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    n_done = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) n_done++;
    end
    chk("mid reset no done", 32'(n_done), 32'd0);
    chk("mid reset start ignored", {31'd0, busy}, 32'd0);

    run_div("after reset 1/3", 32'h0000_8000, 32'h0001_8000, 32'h0000_2AAA, 1'b0, 1'b0, 47);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
